// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi4_lite_pkg;

  // Default geometry: 16-bit byte address, 4-byte data bus.
  localparam int unsigned A_DEF = 16;
  localparam int unsigned N_DEF = 4;

  // AXI response encodings, passed through untouched.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Transaction sequencing: one outstanding access at a time.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4,
    ST_RSP   = 3'd5
  } state_t;

  // Command and response payloads at the default geometry.
  typedef struct packed {
    logic               wr;
    logic [A_DEF-1:0]   addr;
    logic [N_DEF*8-1:0] wdata;
    logic [N_DEF-1:0]   wstrb;
  } cmd_t;

  typedef struct packed {
    logic               wr;
    logic [N_DEF*8-1:0] rdata;
    logic [1:0]         resp;
  } rsp_t;

endpackage

// File: rtl/axi4_lite_cmd_master_if.sv
// Command/response streams plus AXI4-Lite master channels, bundled.
interface axi4_lite_cmd_master_if #(
  parameter int unsigned A = 16,
  parameter int unsigned N = 4
);

  // Command stream
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_wr;
  logic [A-1:0]     cmd_addr;
  logic [N*8-1:0]   cmd_wdata;
  logic [N-1:0]     cmd_wstrb;

  // Response stream
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_wr;
  logic [N*8-1:0]   rsp_rdata;
  logic [1:0]       rsp_resp;

  // AXI4-Lite write address / data / response
  logic [A-1:0]     awaddr;
  logic [2:0]       awprot;
  logic             awvalid;
  logic             awready;
  logic [N*8-1:0]   wdata;
  logic [N-1:0]     wstrb;
  logic             wvalid;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;

  // AXI4-Lite read address / data
  logic [A-1:0]     araddr;
  logic [2:0]       arprot;
  logic             arvalid;
  logic             arready;
  logic [N*8-1:0]   rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;

  // Initiator view (the command master itself)
  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_wr, rsp_rdata, rsp_resp,
    input  rsp_ready,
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  // Environment view (command source, response sink and AXI slave)
  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_wr, rsp_rdata, rsp_resp,
    output rsp_ready,
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_lite_cmd_master.sv
// AXI4-Lite initiator: turns one command into one read or write
// transaction and returns its result on the response stream.
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned A = 16,
  parameter int unsigned N = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi4_lite_cmd_master_if.master bus
);

  localparam int unsigned DW = N * 8;

  typedef struct packed {
    logic          wr;
    logic [A-1:0]  addr;
    logic [DW-1:0] wdata;
    logic [N-1:0]  wstrb;
  } cmd_pl_t;

  typedef struct packed {
    logic          wr;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_pl_t;

  state_t  r_state;
  cmd_pl_t r_cmd;
  rsp_pl_t r_rsp;
  logic    r_awvalid;
  logic    r_wvalid;
  logic    r_arvalid;
  logic    r_bready;
  logic    r_rready;
  logic    r_rsp_valid;

  // A channel is still pending if its valid is up and no handshake this cycle.
  logic w_aw_pend;
  logic w_w_pend;

  assign w_aw_pend = r_awvalid && !bus.awready;
  assign w_w_pend  = r_wvalid  && !bus.wready;

  // Command acceptance is a pure function of state, blocked during reset.
  assign bus.cmd_ready = (r_state == ST_IDLE) && !areset;

  assign bus.awaddr    = r_cmd.addr;
  assign bus.awprot    = 3'b000;
  assign bus.awvalid   = r_awvalid;
  assign bus.wdata     = r_cmd.wdata;
  assign bus.wstrb     = r_cmd.wstrb;
  assign bus.wvalid    = r_wvalid;
  assign bus.bready    = r_bready;
  assign bus.araddr    = r_cmd.addr;
  assign bus.arprot    = 3'b000;
  assign bus.arvalid   = r_arvalid;
  assign bus.rready    = r_rready;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_wr    = r_rsp.wr;
  assign bus.rsp_rdata = r_rsp.rdata;
  assign bus.rsp_resp  = r_rsp.resp;

  // Transaction FSM with all channel controls and captures registered.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_rsp       <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_cmd <= cmd_pl_t'{wr:    bus.cmd_wr,
                               addr:  bus.cmd_addr,
                               wdata: bus.cmd_wdata,
                               wstrb: bus.cmd_wstrb};
            if (bus.cmd_wr) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_AR;
            end
          end
        end

        // AW and W retire independently; B is opened once both are done.
        ST_WR: begin
          if (r_awvalid && bus.awready) r_awvalid <= 1'b0;
          if (r_wvalid && bus.wready)   r_wvalid  <= 1'b0;
          if (!w_aw_pend && !w_w_pend) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_B;
          end
        end

        ST_WR_B: begin
          if (bus.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp       <= rsp_pl_t'{wr: 1'b1, rdata: '0, resp: bus.bresp};
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end

        ST_RD_AR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_R;
          end
        end

        ST_RD_R: begin
          if (bus.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp       <= rsp_pl_t'{wr: 1'b0, rdata: bus.rdata, resp: bus.rresp};
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end

        // Result held stable until the sink takes it.
        ST_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Self-checking bench: behavioural AXI4-Lite slave with memory,
// expected responses queued at issue time and compared on delivery.
module tb_axi4_lite_cmd_master;
  import axi4_lite_pkg::*;

  localparam int unsigned A  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = N * 8;

  logic aclk   = 1'b0;
  logic areset = 1'b1;

  always #5 aclk = ~aclk;

  axi4_lite_cmd_master_if #(.A(A), .N(N)) bus ();

  axi4_lite_cmd_master #(.A(A), .N(N)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  typedef struct {
    logic          wr;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Slave configuration
  int            aw_lat = 0;
  int            w_lat  = 0;
  bit            force_r = 1'b0;
  logic [DW-1:0] force_rdata = '0;
  logic [1:0]    force_rresp = 2'b00;
  logic [1:0]    bresp_cfg   = 2'b00;
  logic [DW-1:0] mem [0:63];

  // Slave state
  bit            got_aw, got_w;
  int            aw_cnt, w_cnt;
  logic [A-1:0]  s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [N-1:0]  s_wstrb;

  function automatic exp_t mk(input logic wr, input logic [DW-1:0] rd, input logic [1:0] rs);
    exp_t e;
    e.wr = wr; e.rdata = rd; e.resp = rs;
    return e;
  endfunction

  // Slave: sample handshakes on the edge, update its drives just after.
  always begin : slave
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, rst;
    @(posedge aclk);
    rst   = areset;
    hs_aw = bus.awvalid && bus.awready;
    hs_w  = bus.wvalid  && bus.wready;
    hs_b  = bus.bvalid  && bus.bready;
    hs_ar = bus.arvalid && bus.arready;
    hs_r  = bus.rvalid  && bus.rready;
    if (hs_aw) s_awaddr = bus.awaddr;
    if (hs_w) begin s_wdata = bus.wdata; s_wstrb = bus.wstrb; end
    if (hs_ar) s_araddr = bus.araddr;
    #1;
    if (rst) begin
      got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
      bus.awready = 0; bus.wready = 0; bus.arready = 0;
      bus.bvalid = 0; bus.bresp = 0;
      bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
    end else begin
      if (hs_aw) got_aw = 1;
      if (hs_w)  got_w  = 1;
      if (hs_b)  bus.bvalid = 0;
      if (hs_r)  bus.rvalid = 0;
      if (got_aw && got_w) begin
        for (int i = 0; i < N; i++)
          if (s_wstrb[i]) mem[s_awaddr[7:2]][i*8 +: 8] = s_wdata[i*8 +: 8];
        got_aw = 0; got_w = 0;
        bus.bvalid = 1; bus.bresp = bresp_cfg;
      end
      if (hs_ar) begin
        bus.rvalid = 1;
        bus.rdata  = force_r ? force_rdata : mem[s_araddr[7:2]];
        bus.rresp  = force_r ? force_rresp : OKAY;
      end
      aw_cnt = (bus.awvalid === 1'b1) ? aw_cnt + 1 : 0;
      w_cnt  = (bus.wvalid  === 1'b1) ? w_cnt + 1  : 0;
      bus.awready = (bus.awvalid === 1'b1) && (aw_cnt > aw_lat);
      bus.wready  = (bus.wvalid  === 1'b1) && (w_cnt > w_lat);
      bus.arready = (bus.arvalid === 1'b1);
    end
  end

  // Drive one command and return at the falling edge after it is accepted.
  task automatic issue(input logic wr, input logic [A-1:0] addr,
                       input logic [DW-1:0] wd, input logic [N-1:0] st, output bit ok);
    ok = 0;
    @(negedge aclk);
    bus.cmd_valid = 1; bus.cmd_wr = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = wd; bus.cmd_wstrb = st;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready === 1'b1) begin @(posedge aclk); ok = 1; break; end
      @(negedge aclk);
    end
    @(negedge aclk);
    bus.cmd_valid = 0;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL cmd_accept_timeout: accepted=0 required=1 addr=%h", addr);
    end
  endtask

  // Wait for a response, take it, return at the falling edge after the handshake.
  task automatic get_rsp(output logic wr, output logic [DW-1:0] rd, output logic [1:0] rs, output bit ok);
    ok = 0; wr = 0; rd = 0; rs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (bus.rsp_valid === 1'b1) begin
        wr = bus.rsp_wr; rd = bus.rsp_rdata; rs = bus.rsp_resp;
        bus.rsp_ready = 1;
        @(posedge aclk);
        ok = 1;
        break;
      end
    end
    @(negedge aclk);
    bus.rsp_ready = 0;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL rsp_timeout: rsp_valid=0 required=1");
    end
  endtask

  task automatic test_reset();
    areset = 1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready);
    end
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_valids: got aw=%b w=%b ar=%b b=%b r=%b rsp=%b want all 0",
               bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid);
    end
    checks++;
    if ({bus.rsp_rdata, bus.rsp_resp, bus.awaddr, bus.wdata, bus.wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got rdata=%h resp=%0d addr=%h wdata=%h wstrb=%h want 0",
               bus.rsp_rdata, bus.rsp_resp, bus.awaddr, bus.wdata, bus.wstrb);
    end
    areset = 0;
    @(negedge aclk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_cmd_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_read();
    bit ok; logic wr; logic [DW-1:0] rd; logic [1:0] rs; exp_t e;
    force_r = 1; force_rdata = 32'hbaadc0de; force_rresp = OKAY;
    sb.push_back(mk(1'b0, 32'hbaadc0de, OKAY));
    issue(1'b0, 16'h0004, '0, '0, ok);
    checks++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, 16'h0004}) begin
      errors++; $display("FAIL read_ar: got arvalid=%b araddr=%h want 1 0004", bus.arvalid, bus.araddr);
    end
    get_rsp(wr, rd, rs, ok);
    e = sb.pop_front();
    checks++;
    if ({wr, rd, rs} !== {e.wr, e.rdata, e.resp}) begin
      errors++; $display("FAIL read_rsp: got wr=%b rdata=%h resp=%0d want wr=%b rdata=%h resp=%0d",
                         wr, rd, rs, e.wr, e.rdata, e.resp);
    end
    force_r = 0;
  endtask

  task automatic test_write_read();
    bit ok; logic wr; logic [DW-1:0] rd; logic [1:0] rs; exp_t e;
    logic          op_wr [5];
    logic [A-1:0]  op_a  [5];
    logic [DW-1:0] op_d  [5];
    logic [N-1:0]  op_s  [5];
    logic [DW-1:0] op_e  [5];
    op_wr = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    op_a  = '{16'h0004, 16'h0004, 16'h0008, 16'h0008, 16'h0008};
    op_d  = '{32'habbabeef, 32'h0, 32'h11223344, 32'haabbccdd, 32'h0};
    op_s  = '{4'hf, 4'h0, 4'hf, 4'b0101, 4'h0};
    op_e  = '{32'h0, 32'habbabeef, 32'h0, 32'h0, 32'h11bb33dd};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(op_wr[i], op_e[i], OKAY));
      issue(op_wr[i], op_a[i], op_d[i], op_s[i], ok);
      get_rsp(wr, rd, rs, ok);
      e = sb.pop_front();
      checks++;
      if ({wr, rd, rs} !== {e.wr, e.rdata, e.resp}) begin
        errors++; $display("FAIL wr_rd_op%0d: got wr=%b rdata=%h resp=%0d want wr=%b rdata=%h resp=%0d",
                           i, wr, rd, rs, e.wr, e.rdata, e.resp);
      end
    end
  endtask

  task automatic test_write_stall();
    bit ok, saw_b; logic wr; logic [DW-1:0] rd; logic [1:0] rs; exp_t e;
    int aw_hi, w_hi, w_bad, b_early;
    aw_lat = 1; w_lat = 3; bresp_cfg = EXOKAY;
    aw_hi = 0; w_hi = 0; w_bad = 0; b_early = 0; saw_b = 0;
    sb.push_back(mk(1'b1, '0, EXOKAY));
    issue(1'b1, 16'h0004, 32'habbabeef, 4'hf, ok);
    for (int i = 0; i < 20; i++) begin
      if (bus.bready === 1'b1) begin
        saw_b = 1;
        if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0) b_early++;
        break;
      end
      if (bus.awvalid === 1'b1) begin
        aw_hi++;
        if (bus.awaddr !== 16'h0004) w_bad++;
      end
      if (bus.wvalid === 1'b1) begin
        w_hi++;
        if ({bus.wdata, bus.wstrb} !== {32'habbabeef, 4'hf}) w_bad++;
      end
      @(negedge aclk);
    end
    checks++;
    if (aw_hi != 2) begin errors++; $display("FAIL stall_awvalid_cycles: got %0d want 2", aw_hi); end
    checks++;
    if (w_hi != 4) begin errors++; $display("FAIL stall_wvalid_cycles: got %0d want 4", w_hi); end
    checks++;
    if (w_bad != 0) begin errors++; $display("FAIL stall_payload_stable: got %0d changes want 0", w_bad); end
    checks++;
    if (!saw_b || b_early != 0) begin
      errors++; $display("FAIL stall_bready: got seen=%0b early=%0d want seen=1 early=0", saw_b, b_early);
    end
    get_rsp(wr, rd, rs, ok);
    e = sb.pop_front();
    checks++;
    if ({wr, rd, rs} !== {e.wr, e.rdata, e.resp}) begin
      errors++; $display("FAIL stall_rsp: got wr=%b rdata=%h resp=%0d want wr=%b rdata=%h resp=%0d",
                         wr, rd, rs, e.wr, e.rdata, e.resp);
    end
    aw_lat = 0; w_lat = 0; bresp_cfg = OKAY;
  endtask

  task automatic test_error_resp();
    bit ok; logic wr; logic [DW-1:0] rd; logic [1:0] rs; exp_t e;
    force_r = 1; force_rdata = 32'hdeadbeef; force_rresp = DECERR;
    sb.push_back(mk(1'b0, 32'hdeadbeef, DECERR));
    issue(1'b0, 16'h0010, '0, '0, ok);
    get_rsp(wr, rd, rs, ok);
    e = sb.pop_front();
    checks++;
    if ({wr, rd, rs} !== {e.wr, e.rdata, e.resp}) begin
      errors++; $display("FAIL err_rsp: got wr=%b rdata=%h resp=%0d want wr=%b rdata=%h resp=%0d",
                         wr, rd, rs, e.wr, e.rdata, e.resp);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL err_back_to_idle: cmd_ready got %b want 1", bus.cmd_ready);
    end
    force_r = 0;
  endtask

  task automatic test_back_to_back();
    bit ok, found; logic wr; logic [DW-1:0] rd; logic [1:0] rs; exp_t e;
    logic [DW+2:0] snap;
    int bad;
    sb.push_back(mk(1'b0, 32'hc0ffee03, OKAY));
    issue(1'b0, 16'h000c, '0, '0, ok);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid === 1'b1) begin found = 1; break; end
      @(negedge aclk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_rsp_timeout: rsp_valid=0 required=1"); end
    snap = {bus.rsp_wr, bus.rsp_rdata, bus.rsp_resp};
    bus.cmd_valid = 1; bus.cmd_wr = 0; bus.cmd_addr = 16'h0004;
    bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
    bad = 0;
    repeat (5) begin
      @(negedge aclk);
      if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_rdata, bus.rsp_resp} !== {1'b1, snap} ||
          bus.cmd_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_hold: got %0d unstable cycles want 0", bad); end
    e = sb.pop_front();
    checks++;
    if (snap !== {e.wr, e.rdata, e.resp}) begin
      errors++; $display("FAIL b2b_first_rsp: got %h want wr=%b rdata=%h resp=%0d", snap, e.wr, e.rdata, e.resp);
    end
    sb.push_back(mk(1'b0, 32'habbabeef, OKAY));
    bus.rsp_ready = 1;
    @(posedge aclk);
    @(negedge aclk);
    bus.rsp_ready = 0;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_after_hs: got cmd_ready=%b rsp_valid=%b want 1 0", bus.cmd_ready, bus.rsp_valid);
    end
    @(posedge aclk);
    @(negedge aclk);
    bus.cmd_valid = 0;
    checks++;
    if ({bus.arvalid, bus.araddr} !== {1'b1, 16'h0004}) begin
      errors++; $display("FAIL b2b_accept: got arvalid=%b araddr=%h want 1 0004", bus.arvalid, bus.araddr);
    end
    get_rsp(wr, rd, rs, ok);
    e = sb.pop_front();
    checks++;
    if ({wr, rd, rs} !== {e.wr, e.rdata, e.resp}) begin
      errors++; $display("FAIL b2b_second_rsp: got wr=%b rdata=%h resp=%0d want wr=%b rdata=%h resp=%0d",
                         wr, rd, rs, e.wr, e.rdata, e.resp);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic wr; logic [DW-1:0] rd; logic [1:0] rs; exp_t e;
    aw_lat = 3; w_lat = 3;
    issue(1'b1, 16'h0020, 32'h55aa55aa, 4'hf, ok);
    checks++;
    if (bus.awvalid !== 1'b1) begin errors++; $display("FAIL mid_awvalid: got %b want 1", bus.awvalid); end
    areset = 1;
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid, bus.cmd_ready} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got aw=%b w=%b ar=%b b=%b r=%b rsp=%b cr=%b want all 0",
               bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.rsp_valid, bus.cmd_ready);
    end
    areset = 0; aw_lat = 0; w_lat = 0;
    @(negedge aclk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.awvalid !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release: got cmd_ready=%b awvalid=%b rsp_valid=%b want 1 0 0",
                         bus.cmd_ready, bus.awvalid, bus.rsp_valid);
    end
    // The abandoned write must not have reached memory.
    sb.push_back(mk(1'b0, 32'h0, OKAY));
    issue(1'b0, 16'h0020, '0, '0, ok);
    get_rsp(wr, rd, rs, ok);
    e = sb.pop_front();
    checks++;
    if ({wr, rd, rs} !== {e.wr, e.rdata, e.resp}) begin
      errors++; $display("FAIL mid_after_read: got wr=%b rdata=%h resp=%0d want wr=%b rdata=%h resp=%0d",
                         wr, rd, rs, e.wr, e.rdata, e.resp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[3] = 32'hc0ffee03;
    bus.cmd_valid = 0; bus.cmd_wr = 0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 0;

    test_reset();
    test_read();
    test_write_read();
    test_write_stall();
    test_error_resp();
    test_back_to_back();
    test_reset_mid();

    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
